alu_dmem_unit: RTL and testbench
================================

Name: alu_dmem_unit

Overview:
- Execute/memory datapath slice of the 16-bit pipelined MIPS-style core. It contains three pieces:
  - ALU control decoder: maps ALUOp plus the instruction function field to a 4-bit operation code.
  - 16-bit ALU: produces a result and the zero/lt/gt branch flags.
  - Word-addressed data memory: synchronous write, combinational read.
- The ALU and decoder are purely combinational. The memory is the only state.

Parameters:
- ADDR_BITS, 8, number of address bits used to index data memory. Depth is 2**ADDR_BITS 16-bit words.

Ports:
- clk  input  1  clock; memory writes on the rising edge.
- rst_n  input  1  asynchronous active-low reset; clears all memory words.
- alu_op  input  3  ALUOp from the control unit.
- func  input  3  instruction function field, bits [2:0].
- data1  input  16  ALU operand A.
- data2  input  16  ALU operand B (register value or sign-extended immediate).
- aluoperation  output  4  decoded operation code.
- result  output  16  ALU result.
- zero  output  1  result == 0.
- lt  output  1  signed data1 < data2.
- gt  output  1  signed data1 > data2.
- memread  input  1  read enable.
- memwrite  input  1  write enable.
- address  input  16  word address; only [ADDR_BITS-1:0] is used.
- writedata  input  16  store data.
- readdata  output  16  load data.

Behaviour:
- ALU operation codes, all 16-bit with wrap-around and no carry/overflow output:
  - 0000 ADD; 0001 SUB (data1-data2); 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLT: result = 1 if signed data1 < data2, else 0.
  - 0111 SLL: data1 << data2[3:0].
  - 1000 SRL: logical shift right by data2[3:0].
  - 1001 SRA: arithmetic shift right by data2[3:0].
  - 1010-1111: result = 0.
- Flags:
  - zero = (result == 16'h0000), for every operation code, including undefined codes (which therefore give zero = 1).
  - lt/gt compare data1 and data2 as signed values, independent of the operation code; both are 0 when the operands are equal.
- ALU control decode:
  - alu_op 000 (R-type): func selects the code: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SLT, 111 SLL.
  - alu_op 001 ADD (loads, stores, addi); 010 SUB (branches); 011 AND; 100 OR; 101 SLT; 110 SRL; 111 SRA.
- Data memory:
  - Array of 2**ADDR_BITS x 16 bits, indexed by address[ADDR_BITS-1:0]. Upper address bits are ignored, so addresses wrap modulo depth.
  - Write: on posedge clk when memwrite = 1 and rst_n = 1, mem[idx] <= writedata.
  - Read is combinational: readdata = mem[idx] when memread = 1, else 16'h0000.
  - Read of the address being written in the same cycle returns the old value until the clock edge and the new value after it.
  - memread and memwrite both high: the write occurs and readdata shows the old value during that cycle.
- Reset:
  - rst_n low immediately (asynchronously) clears every memory word to 0, so readdata = 0 while memread is asserted.
  - Writes are blocked while rst_n is low; a reset asserted during a write cycle wins.
  - Combinational outputs are unaffected by reset.
- Latency: ALU, decoder and read path are 0 cycles; writes take effect after 1 clock edge.

Test Plan:
- Decode sweep: alu_op 000 with func 000..111 → aluoperation 0000..0111. alu_op 001..111 → 0000, 0001, 0010, 0011, 0110, 1000, 1001.
- ALU arithmetic:
  - ADD 16'h7FFF + 1 → 16'h8000, zero = 0.
  - SUB 5 - 5 → 0, zero = 1, lt = gt = 0.
  - SUB 16'hFFFF(-1) - 1 → 16'hFFFE, lt = 1, gt = 0.
- Logic and shifts:
  - AND 16'hF0F0 & 16'h0FF0 → 16'h00F0.
  - NOR 0,0 → 16'hFFFF.
  - SLL 16'h0001 by 16'h0013 → 16'h0008 (only data2[3:0] = 3 is used).
  - SRA 16'h8000 by 15 → 16'hFFFF; SRL 16'h8000 by 15 → 16'h0001.
  - SLT -2 vs 3 → result 1.
- Memory write/read:
  - Write 16'hBEEF to address 4 with memwrite = 1, memread = 1: readdata stays 0 before the edge and shows BEEF after it.
  - Read of address 16'h0104 (ADDR_BITS = 8) → BEEF via wrap.
  - memread = 0 → readdata 0.
- Reset: after writing several words, pulse rst_n low mid-cycle → all reads return 0 immediately. A memwrite held during reset writes nothing.
- Simultaneous events: memwrite = 1 to address 9 in the same cycle rst_n deasserts asynchronously before the edge → the word is written at that edge. Undefined aluoperation codes (e.g. 1010 forced via an internal probe or decode) → result 0, zero = 1.

Source files
------------

// File: rtl/alu_dmem_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_dmem_unit
// Purpose  : Execute/memory slice of the 16-bit MIPS-style core. It combines
//            the ALU control decode, a 16-bit ALU with branch flags, and a
//            word-addressed data memory.
// Revision : 1.0 - initial release
// ============================================================================
module alu_dmem_unit #(
  parameter int ADDR_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  alu_op,
  input  logic [2:0]  func,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [3:0]  aluoperation,
  output logic [15:0] result,
  output logic        zero,
  output logic        lt,
  output logic        gt,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] address,
  input  logic [15:0] writedata,
  output logic [15:0] readdata
);

  localparam int c_DEPTH = 1 << ADDR_BITS;

  localparam logic [3:0] c_OP_ADD = 4'b0000;
  localparam logic [3:0] c_OP_SUB = 4'b0001;
  localparam logic [3:0] c_OP_AND = 4'b0010;
  localparam logic [3:0] c_OP_OR  = 4'b0011;
  localparam logic [3:0] c_OP_XOR = 4'b0100;
  localparam logic [3:0] c_OP_NOR = 4'b0101;
  localparam logic [3:0] c_OP_SLT = 4'b0110;
  localparam logic [3:0] c_OP_SLL = 4'b0111;
  localparam logic [3:0] c_OP_SRL = 4'b1000;
  localparam logic [3:0] c_OP_SRA = 4'b1001;

  logic [3:0]           w_aluop;
  logic [15:0]          w_result;
  logic [3:0]           w_shamt;
  logic                 w_lt;
  logic                 w_gt;
  logic [ADDR_BITS-1:0] w_idx;
  logic [15:0]          r_mem [c_DEPTH];

  // R-type function codes map one-to-one onto the first eight op codes.
  always_comb begin
    w_aluop = c_OP_ADD;
    case (alu_op)
      3'b000:  w_aluop = {1'b0, func};
      3'b001:  w_aluop = c_OP_ADD;
      3'b010:  w_aluop = c_OP_SUB;
      3'b011:  w_aluop = c_OP_AND;
      3'b100:  w_aluop = c_OP_OR;
      3'b101:  w_aluop = c_OP_SLT;
      3'b110:  w_aluop = c_OP_SRL;
      3'b111:  w_aluop = c_OP_SRA;
      default: w_aluop = c_OP_ADD;
    endcase
  end

  assign w_shamt = data2[3:0];
  assign w_lt    = $signed(data1) < $signed(data2);
  assign w_gt    = $signed(data1) > $signed(data2);

  always_comb begin
    w_result = 16'h0000;
    case (w_aluop)
      c_OP_ADD: w_result = data1 + data2;
      c_OP_SUB: w_result = data1 - data2;
      c_OP_AND: w_result = data1 & data2;
      c_OP_OR:  w_result = data1 | data2;
      c_OP_XOR: w_result = data1 ^ data2;
      c_OP_NOR: w_result = ~(data1 | data2);
      c_OP_SLT: w_result = {15'h0000, w_lt};
      c_OP_SLL: w_result = data1 << w_shamt;
      c_OP_SRL: w_result = data1 >> w_shamt;
      c_OP_SRA: w_result = $unsigned($signed(data1) >>> w_shamt);
      default:  w_result = 16'h0000;
    endcase
  end

  assign aluoperation = w_aluop;
  assign result       = w_result;
  assign zero         = (w_result == 16'h0000);
  assign lt           = w_lt;
  assign gt           = w_gt;

  assign w_idx = address[ADDR_BITS-1:0];

  // Upper address bits are deliberately ignored so that addresses wrap.
  generate
    if (ADDR_BITS < 16) begin : g_addr_unused
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^address[15:ADDR_BITS];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
    end else if (memwrite) begin
      r_mem[w_idx] <= writedata;
    end
  end

  assign readdata = memread ? r_mem[w_idx] : 16'h0000;

endmodule
`default_nettype wire

// File: tb/tb_alu_dmem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_dmem_unit
// Purpose  : Self-checking bench for alu_dmem_unit against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_dmem_unit;

  logic        clk;
  logic        rst_n;
  logic [2:0]  alu_op;
  logic [2:0]  func;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [3:0]  aluoperation;
  logic [15:0] result;
  logic        zero;
  logic        lt;
  logic        gt;
  logic        memread;
  logic        memwrite;
  logic [15:0] address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  int n_tests;
  int n_fail;
  int model_mem [256];

  alu_dmem_unit #(.ADDR_BITS(8)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_op       (alu_op),
    .func         (func),
    .data1        (data1),
    .data2        (data2),
    .aluoperation (aluoperation),
    .result       (result),
    .zero         (zero),
    .lt           (lt),
    .gt           (gt),
    .memread      (memread),
    .memwrite     (memwrite),
    .address      (address),
    .writedata    (writedata),
    .readdata     (readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int to_signed16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic int exp_op(input int aop, input int f);
    int tbl [8];
    tbl = '{0, 0, 1, 2, 3, 6, 8, 9};
    return (aop == 0) ? f : tbl[aop];
  endfunction

  function automatic int exp_res(input int op, input int a, input int b);
    int sa, sb, sh;
    sa = to_signed16(a);
    sb = to_signed16(b);
    sh = b % 16;
    case (op)
      0: return (a + b) % 65536;
      1: return (a - b + 65536) % 65536;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 65535 - (a | b);
      6: return (sa < sb) ? 1 : 0;
      7: return (a * (1 << sh)) % 65536;
      8: return a / (1 << sh);
      9: return (sa >>> sh) & 65535;
      default: return 0;
    endcase
  endfunction

  // Apply operands, then check every ALU output against the model.
  task automatic alu_check(input string tag, input int aop, input int f,
                           input int a, input int b);
    int op, r;
    alu_op = aop[2:0];
    func   = f[2:0];
    data1  = a[15:0];
    data2  = b[15:0];
    #1;
    op = exp_op(aop, f);
    r  = exp_res(op, a, b);
    chk({tag, ".op"},   int'(aluoperation), op);
    chk({tag, ".res"},  int'(result), r);
    chk({tag, ".zero"}, int'(zero), (r == 0) ? 1 : 0);
    chk({tag, ".lt"},   int'(lt), (to_signed16(a) < to_signed16(b)) ? 1 : 0);
    chk({tag, ".gt"},   int'(gt), (to_signed16(a) > to_signed16(b)) ? 1 : 0);
  endtask

  task automatic mem_read_check(input string tag, input int addr);
    memwrite = 1'b0;
    memread  = 1'b1;
    address  = addr[15:0];
    #1;
    chk(tag, int'(readdata), model_mem[addr % 256]);
  endtask

  // Write with memread high: old value before the edge, new value after.
  task automatic mem_write(input string tag, input int addr, input int wd);
    @(negedge clk);
    memread   = 1'b1;
    memwrite  = 1'b1;
    address   = addr[15:0];
    writedata = wd[15:0];
    #1;
    chk({tag, ".pre"}, int'(readdata), model_mem[addr % 256]);
    @(posedge clk);
    model_mem[addr % 256] = wd;
    #1;
    chk({tag, ".post"}, int'(readdata), wd);
    memwrite = 1'b0;
  endtask

  initial begin
    int a, b, aop, f, addr, wd, rd, wr;
    n_tests = 0;
    n_fail  = 0;
    foreach (model_mem[i]) model_mem[i] = 0;
    rst_n = 1'b0; alu_op = 3'b0; func = 3'b0; data1 = '0; data2 = '0;
    memread = 1'b1; memwrite = 1'b0; address = 16'd4; writedata = '0;
    #2;
    chk("reset.readdata", int'(readdata), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep plus directed ALU corner cases.
    for (int i = 0; i < 8; i++) alu_check("dec_r", 0, i, 16'h1234, 16'h0F0F);
    for (int i = 1; i < 8; i++) alu_check("dec_i", i, 0, 16'h8421, 16'h0003);
    alu_check("add_ovf", 1, 0, 16'h7FFF, 1);
    chk("add_ovf.const", int'(result), 16'h8000);
    alu_check("sub_eq", 2, 0, 5, 5);
    chk("sub_eq.zero", int'(zero), 1);
    alu_check("sub_neg", 2, 0, 16'hFFFF, 1);
    chk("sub_neg.const", int'(result), 16'hFFFE);
    chk("sub_neg.lt", int'(lt), 1);
    alu_check("and", 0, 2, 16'hF0F0, 16'h0FF0);
    chk("and.const", int'(result), 16'h00F0);
    alu_check("nor", 0, 5, 0, 0);
    chk("nor.const", int'(result), 16'hFFFF);
    alu_check("sll", 0, 7, 16'h0001, 16'h0013);
    chk("sll.const", int'(result), 16'h0008);
    alu_check("sra", 7, 0, 16'h8000, 15);
    chk("sra.const", int'(result), 16'hFFFF);
    alu_check("srl", 6, 0, 16'h8000, 15);
    chk("srl.const", int'(result), 16'h0001);
    alu_check("slt", 5, 0, 16'hFFFE, 3);
    chk("slt.const", int'(result), 1);

    for (int i = 0; i < 200; i++) begin
      aop = $urandom_range(0, 7);
      f   = $urandom_range(0, 7);
      a   = $urandom_range(0, 65535);
      b   = (i % 4 == 0) ? a : $urandom_range(0, 65535);
      alu_check("rand_alu", aop, f, a, b);
    end

    // Memory write/read, wrap and read-disable.
    mem_write("wr4", 4, 16'hBEEF);
    @(negedge clk);
    mem_read_check("wrap", 16'h0104);
    chk("wrap.const", int'(readdata), 16'hBEEF);
    memread = 1'b0;
    #1;
    chk("rd_disabled", int'(readdata), 0);

    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      rd   = $urandom_range(0, 1);
      wr   = $urandom_range(0, 1);
      addr = ($urandom_range(0, 255) << 8) | $urandom_range(0, 15);
      wd   = $urandom_range(0, 65535);
      memread = rd[0]; memwrite = wr[0];
      address = addr[15:0]; writedata = wd[15:0];
      #1;
      chk("rand_mem", int'(readdata), rd ? model_mem[addr % 256] : 0);
      @(posedge clk);
      if (wr != 0) model_mem[addr % 256] = wd;
    end
    @(negedge clk);
    memwrite = 1'b0;

    // Asynchronous reset mid-cycle clears every word; a held write is blocked.
    mem_write("wr7", 7, 16'h1357);
    mem_write("wr200", 200, 16'hA5A5);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    foreach (model_mem[i]) model_mem[i] = 0;
    mem_read_check("rst_clr7", 7);
    mem_read_check("rst_clr200", 200);
    mem_read_check("rst_clr4", 4);
    memwrite = 1'b1; address = 16'd12; writedata = 16'h7777;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
    rst_n = 1'b1;
    mem_read_check("rst_blk_wr", 12);

    // Reset released before the edge of a write cycle: write lands.
    @(negedge clk);
    rst_n = 1'b0;
    memread = 1'b1; memwrite = 1'b1; address = 16'd9; writedata = 16'h0909;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    model_mem[9] = 16'h0909;
    #1;
    memwrite = 1'b0;
    mem_read_check("rst_rel_wr9", 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
